// File: rtl/vga_timing_out.sv
// Raster timing generator and registered VGA output stage (drawcon pixel producer).
// Define VGA_BRAM_COMP_EN to add one decode stage matching a synchronous image ROM.
module vga_timing_out #(
  parameter int H_ACTIVE = 1440,
  parameter int H_FP     = 80,
  parameter int H_SYNC   = 152,
  parameter int H_BP     = 232,
  parameter int V_ACTIVE = 900,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 28,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic [3:0]  draw_r,
  input  logic [3:0]  draw_g,
  input  logic [3:0]  draw_b,
  output logic [10:0] curr_x,
  output logic [10:0] curr_y,
  output logic [3:0]  pix_r,
  output logic [3:0]  pix_g,
  output logic [3:0]  pix_b,
  output logic        hsync,
  output logic        vsync,
  output logic        active,
  output logic        frame_tick
);

  localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] H_SS     = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SE     = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] H_LAST   = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0] V_SS     = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SE     = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] V_LAST   = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [10:0] V_ACT_LS = 11'(V_ACTIVE - 1);

  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
  } ctl_t;

  localparam ctl_t CTL_RST = '{act: 1'b0, hs: ~H_POL, vs: ~V_POL};

  logic [10:0] hcnt, vcnt;
  ctl_t        ctl0, ctl_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (ce) begin
      if (hcnt == H_LAST) begin
        hcnt <= '0;
        vcnt <= (vcnt == V_LAST) ? 11'd0 : vcnt + 11'd1;
      end else begin
        hcnt <= hcnt + 11'd1;
      end
    end
  end

  assign curr_x = hcnt;
  assign curr_y = vcnt;

  // vsync decodes only vcnt, so its edges land on the hcnt=0 boundary
  always_comb begin
    ctl0.act = (hcnt < H_ACT) && (vcnt < V_ACT);
    ctl0.hs  = ((hcnt >= H_SS) && (hcnt < H_SE)) ? H_POL : ~H_POL;
    ctl0.vs  = ((vcnt >= V_SS) && (vcnt < V_SE)) ? V_POL : ~V_POL;
  end

`ifdef VGA_BRAM_COMP_EN
  // draw_* lags the counters by one ce-cycle, so delay the decode to match
  ctl_t ctl1;
  always_ff @(posedge clk) begin
    if (!rst)    ctl1 <= CTL_RST;
    else if (ce) ctl1 <= ctl0;
  end
  assign ctl_q = ctl1;
`else
  assign ctl_q = ctl0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      pix_r  <= '0;
      pix_g  <= '0;
      pix_b  <= '0;
      active <= 1'b0;
      hsync  <= ~H_POL;
      vsync  <= ~V_POL;
    end else if (ce) begin
      pix_r  <= ctl_q.act ? draw_r : 4'd0;
      pix_g  <= ctl_q.act ? draw_g : 4'd0;
      pix_b  <= ctl_q.act ? draw_b : 4'd0;
      active <= ctl_q.act;
      hsync  <= ctl_q.hs;
      vsync  <= ctl_q.vs;
    end
  end

  // Fires on the step from the last active line into vertical blanking
  always_ff @(posedge clk) begin
    if (!rst)    frame_tick <= 1'b0;
    else if (ce) frame_tick <= (hcnt == H_LAST) && (vcnt == V_ACT_LS);
  end

endmodule

// File: tb/tb_vga_timing_out.sv
// Bench for vga_timing_out: shrunk-geometry instance checked cycle by cycle against a
// reference model, plus a full-size instance for line timing at real parameters.
module tb_vga_timing_out;

  localparam int HA = 16, HF = 4, HS = 6, HB = 6;
  localparam int VA = 10, VF = 1, VS = 3, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
`ifdef VGA_BRAM_COMP_EN
  localparam bit COMP = 1'b1;
`else
  localparam bit COMP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, ce;
  logic [3:0]  dr, dg, db;
  logic [10:0] cx, cy;
  logic [3:0]  pr, pg, pb;
  logic        hs, vs, act, ft;

  logic [10:0] b_cx, b_cy;
  logic [3:0]  b_pr, b_pg, b_pb;
  logic        b_hs, b_vs, b_act, b_ft;

  vga_timing_out #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_POL(1'b0), .V_POL(1'b1)
  ) u_dut (
    .clk(clk), .rst(rst), .ce(ce),
    .draw_r(dr), .draw_g(dg), .draw_b(db),
    .curr_x(cx), .curr_y(cy),
    .pix_r(pr), .pix_g(pg), .pix_b(pb),
    .hsync(hs), .vsync(vs), .active(act), .frame_tick(ft)
  );

  vga_timing_out u_big (
    .clk(clk), .rst(rst), .ce(1'b1),
    .draw_r(4'hF), .draw_g(4'h5), .draw_b(4'hA),
    .curr_x(b_cx), .curr_y(b_cy),
    .pix_r(b_pr), .pix_g(b_pg), .pix_b(b_pb),
    .hsync(b_hs), .vsync(b_vs), .active(b_act), .frame_tick(b_ft)
  );

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // reference model state
  int mh, mv, p1h;
  bit s_act, s_hs, s_vs;
  bit e_act, e_hs, e_vs, e_ft;
  int e_r, e_g, e_b;

  function automatic bit f_act(int h, int v);
    return (h < HA) && (v < VA);
  endfunction
  function automatic bit f_hs(int h);
    return !((h >= HA + HF) && (h < HA + HF + HS));
  endfunction
  function automatic bit f_vs(int v);
    return (v >= VA + VF) && (v < VA + VF + VS);
  endfunction

  task automatic model_reset();
    mh = 0; mv = 0; p1h = 0;
    s_act = 0; s_hs = 1; s_vs = 0;
    e_act = 0; e_hs = 1; e_vs = 0; e_ft = 0;
    e_r = 0; e_g = 0; e_b = 0;
  endtask

  // one clock: drive, edge, advance model, sample 1 time unit later
  task automatic cyc(input bit r, input bit c);
    bit oa, oh, ov;
    rst = r; ce = c;
    dr = COMP ? 4'(p1h) : 4'(mh);
    dg = 4'h5; db = 4'hA;
    @(posedge clk);
    if (!r) model_reset();
    else if (c) begin
      if (COMP) begin
        oa = s_act; oh = s_hs; ov = s_vs;
        s_act = f_act(mh, mv); s_hs = f_hs(mh); s_vs = f_vs(mv);
      end else begin
        oa = f_act(mh, mv); oh = f_hs(mh); ov = f_vs(mv);
      end
      e_act = oa; e_hs = oh; e_vs = ov;
      e_r = oa ? int'(dr) : 0;
      e_g = oa ? 5 : 0;
      e_b = oa ? 10 : 0;
      e_ft = (mh == HT - 1) && (mv == VA - 1);
      p1h = mh;
      if (mh == HT - 1) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end else mh = mh + 1;
    end
    #1;
    chk("curr_x", cx, mh);
    chk("curr_y", cy, mv);
    chk("pix_r", pr, e_r);
    chk("pix_g", pg, e_g);
    chk("pix_b", pb, e_b);
    chk("active", act, e_act);
    chk("hsync", hs, e_hs);
    chk("vsync", vs, e_vs);
    chk("frame_tick", ft, e_ft);
  endtask

  initial begin
    int ft_cnt, f1, r1, f2, xf;
    bit prev_hs;
    model_reset();
    rst = 0; ce = 1; dr = 0; dg = 0; db = 0;
    repeat (3) cyc(0, 1);
    chk("rst_hsync_const", hs, 1);
    chk("rst_vsync_const", vs, 0);

    // run into the middle of a frame, then reset there (ce low: reset must still win)
    for (int i = 0; i < 7 * HT + 20; i++) cyc(1, 1);
    chk("pre_rst_pos_x", cx, 20);
    chk("pre_rst_pos_y", cy, 7);
    cyc(0, 0);
    repeat (2) cyc(0, 1);
    chk("mid_rst_x", cx, 0);
    chk("mid_rst_y", cy, 0);
    chk("mid_rst_pix", {pr, pg, pb}, 0);

    // full frame plus wrap, ce held high
    ft_cnt = 0;
    for (int i = 0; i < VT * HT + 40; i++) begin
      cyc(1, 1);
      if (ft) ft_cnt++;
      if (i == VA * HT - 1) chk("ft_at_0_VA", {ft, cx, cy}, {1'b1, 11'd0, 11'(VA)});
      if (i == VT * HT - 1) chk("wrap_to_0_0", {cx, cy}, 0);
    end
    chk("ft_once_per_frame", ft_cnt, 1);

    // ce alternating across a frame boundary: period doubles, outputs hold on ce=0
    for (int i = 0; i < 2 * VT * HT + 8; i++) cyc(1, (i % 2) == 0);
    // long ce=0 stretch right after a frame_tick: it must stay high
    while (!((mh == HT - 1) && (mv == VA - 1))) cyc(1, 1);
    cyc(1, 1);
    for (int i = 0; i < 5; i++) cyc(1, 0);
    chk("ft_held_ce0", ft, 1);
    cyc(1, 1);
    chk("ft_drops", ft, 0);

    // full-size geometry: line timing of the default-parameter instance
    repeat (2) cyc(0, 1);
    chk("big_rst_hsync", b_hs, 1);
    chk("big_rst_vsync", b_vs, 0);
    chk("big_rst_xy", {b_cx, b_cy}, 0);
    f1 = -1; r1 = -1; f2 = -1; xf = -1; prev_hs = 1;
    for (int i = 0; i < 5000 && f2 < 0; i++) begin
      cyc(1, 1);
      if (prev_hs && !b_hs) begin
        if (f1 < 0) begin
          f1 = i; xf = int'(b_cx);
          chk("big_pix_blank", {b_pr, b_act}, 0);
        end else f2 = i;
      end
      if (!prev_hs && b_hs && r1 < 0) r1 = i;
      if (i == 100) chk("big_pix_active", {b_pr, b_pg, b_pb, b_act}, {12'hF5A, 1'b1});
      prev_hs = b_hs;
    end
    chk("big_hs_fall_x", xf, COMP ? 1522 : 1521);
    chk("big_hs_width", r1 - f1, 152);
    chk("big_line_period", f2 - f1, 1904);
    chk("big_vsync_low", b_vs, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
